bcd_to_bin_seq: RTL

Sequential BCD-to-binary converter. It is the reverse path of the team's binary-to-BCD multiplier/display logic. It accepts a packed multi-digit BCD word under a start/ready handshake and produces the binary value. It uses one multiply-by-10-and-add step per clock, most significant digit first, and pulses `done` when the result is valid. It sits between BCD operand entry (keypad or display registers) and the binary arithmetic datapath.

---
 rtl/bcd_to_bin_seq.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq
//   Sequential packed-BCD to binary converter. One multiply-by-10-and-add
//   step per clock, most significant digit first. A conversion is started
//   with start & ready; done pulses for one cycle when bin_out/err are valid.
//
// Parameters
//   NDIG  number of BCD digits (1..8)
//   BW    result width, 2^BW > 10^NDIG - 1
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   conversion request, sampled only while ready
//   bcd_in   in   [4*NDIG-1:0] packed BCD operand, digit NDIG-1 is the MSD
//   ready    out  idle, a start is accepted
//   busy     out  conversion in progress or done cycle
//   done     out  one-cycle completion pulse
//   bin_out  out  [BW-1:0] binary result, held until the next done
//   err      out  invalid-digit flag of the last conversion
//
// Configuration
//   BCD_TO_BIN_SEQ_CHECK_EN  when defined, nibbles > 9 set err and force
//                            bin_out to 0; otherwise err is tied to 0 and
//                            nibbles are used as raw values 0..15.
//
// state  | meaning
// -------+-----------------------------------------------
// S_IDLE | waiting for start, ready=1
// S_CONV | consuming one digit per cycle, MSD first
// S_DONE | single-cycle done pulse, result registered

module bcd_to_bin_seq #(
  parameter int NDIG = 4,
  parameter int BW   = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [BW-1:0]     bin_out,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [4*NDIG-1:0] sr_q;
  logic [BW-1:0]     acc_q;
  logic [BW-1:0]     bin_q;
  logic [3:0]        cnt_q;
  logic [3:0]        digit;
  logic [BW-1:0]     acc_next;
  logic              last_digit;

  assign digit      = sr_q[4*NDIG-1 -: 4];
  // acc*10 as two shifts; everything stays BW bits, so raw nibbles truncate.
  assign acc_next   = (acc_q << 3) + (acc_q << 1) + BW'(digit);
  assign last_digit = (cnt_q == 4'd1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CONV;
      S_CONV:  if (last_digit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ready   = (state_q == S_IDLE);
  assign busy    = (state_q == S_CONV) || (state_q == S_DONE);
  assign done    = (state_q == S_DONE);
  assign bin_out = bin_q;

`ifdef BCD_TO_BIN_SEQ_CHECK_EN
  logic flag_q;
  logic err_q;
  logic flag_next;

  // The digit being consumed this cycle must be included in the final verdict.
  assign flag_next = flag_q | (digit > 4'd9);
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      bin_q  <= '0;
      flag_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sr_q   <= bcd_in;
            acc_q  <= '0;
            cnt_q  <= 4'(NDIG);
            flag_q <= 1'b0;
          end
        end
        S_CONV: begin
          acc_q  <= acc_next;
          sr_q   <= sr_q << 4;
          cnt_q  <= cnt_q - 4'd1;
          flag_q <= flag_next;
          if (last_digit) begin
            bin_q <= flag_next ? '0 : acc_next;
            err_q <= flag_next;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign err = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      bin_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sr_q  <= bcd_in;
            acc_q <= '0;
            cnt_q <= 4'(NDIG);
          end
        end
        S_CONV: begin
          acc_q <= acc_next;
          sr_q  <= sr_q << 4;
          cnt_q <= cnt_q - 4'd1;
          if (last_digit) bin_q <= acc_next;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule
